// File: rtl/ad9914_reg_rd_if.sv
// ---------------------------------------------------------------------------
// ad9914_reg_rd_if
//
// Bundles the command/status handshake and the AD9914 parallel-port pins of
// the register read-back engine.
//
// Signals:
//   load            start request (level-sampled while the engine is idle)
//   reg_base_addr   address of the first 16-bit word
//   reg_word_num    number of words to read (1 or 2 are legal)
//   exp_var         expected value for the optional verify compare
//   reg_rvar        assembled 32-bit read data
//   res             command error (illegal word count)
//   mismatch        verify failure, valid while finish=1
//   busy            transaction in progress
//   finish          engine idle, last result valid
//   p_pwd           bus width select (always 16-bit)
//   p_wr            write strobe, active-low (always inactive here)
//   p_rd            read strobe, active-low
//   p_addr          port address
//   p_rdata         data returned by the DDS
//   data_tri_select keeps the FPGA data drivers off during reads
//
// Modports:
//   slave   the read engine itself
//   master  everything outside the engine: the controller issuing commands
//           and the DDS pins returning p_rdata
// ---------------------------------------------------------------------------
interface ad9914_reg_rd_if;
  logic        load;
  logic [7:0]  reg_base_addr;
  logic [1:0]  reg_word_num;
  logic [31:0] exp_var;
  logic [31:0] reg_rvar;
  logic        res;
  logic        mismatch;
  logic        busy;
  logic        finish;
  logic        p_pwd;
  logic        p_wr;
  logic        p_rd;
  logic [7:0]  p_addr;
  logic [15:0] p_rdata;
  logic        data_tri_select;

  modport slave (
    input  load, reg_base_addr, reg_word_num, exp_var, p_rdata,
    output reg_rvar, res, mismatch, busy, finish,
           p_pwd, p_wr, p_rd, p_addr, data_tri_select
  );

  modport master (
    output load, reg_base_addr, reg_word_num, exp_var, p_rdata,
    input  reg_rvar, res, mismatch, busy, finish,
           p_pwd, p_wr, p_rd, p_addr, data_tri_select
  );
endinterface

// File: rtl/ad9914_reg_rd.sv
// ---------------------------------------------------------------------------
// ad9914_reg_rd
//
// Read-back engine for the AD9914 16-bit parallel port. On a load request it
// reads one or two consecutive 16-bit registers (addresses base and base+2)
// with timed p_rd strobes and assembles a 32-bit result. Word 0 lands in
// reg_rvar[15:0], word 1 in reg_rvar[31:16]; a 1-word read clears the upper
// half.
//
// Parameters:
//   ADDR_SETUP_NUM  cycles p_addr is stable before p_rd falls (0 -> 1)
//   RD_PULSE_NUM    cycles p_rd is held low                 (0 -> 1)
//   RD_RECOVER_NUM  cycles p_rd stays high after the strobe (0 -> 1)
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   port_if  ad9914_reg_rd_if.slave: command/status and parallel-port pins
//
// Optional feature:
//   AD9914_RD_VERIFY_EN  when defined, the result is compared against
//                        exp_var (masked to the words read) and mismatch
//                        reports the outcome; otherwise mismatch is 0.
// ---------------------------------------------------------------------------
module ad9914_reg_rd #(
  parameter int ADDR_SETUP_NUM = 2,
  parameter int RD_PULSE_NUM   = 4,
  parameter int RD_RECOVER_NUM = 2
) (
  input logic             clk,
  input logic             rst,
  ad9914_reg_rd_if.slave  port_if
);

  // A zero-length phase would collapse the strobe timing, so each phase
  // lasts at least one cycle.
  localparam int S_EFF = (ADDR_SETUP_NUM < 1) ? 1 : ADDR_SETUP_NUM;
  localparam int P_EFF = (RD_PULSE_NUM   < 1) ? 1 : RD_PULSE_NUM;
  localparam int R_EFF = (RD_RECOVER_NUM < 1) ? 1 : RD_RECOVER_NUM;

  localparam logic [15:0] S_LAST = 16'(S_EFF - 1);
  localparam logic [15:0] P_LAST = 16'(P_EFF - 1);
  localparam logic [15:0] R_LAST = 16'(R_EFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        word_idx_q, word_idx_d;
  logic [1:0]  word_num_q, word_num_d;
  logic [7:0]  p_addr_q, p_addr_d;
  logic        p_rd_q, p_rd_d;
  logic [31:0] reg_rvar_q, reg_rvar_d;
  logic        res_q, res_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;
`ifdef AD9914_RD_VERIFY_EN
  logic [31:0] exp_q, exp_d;
  logic        mismatch_q, mismatch_d;
`endif

  logic cmd_legal;
  logic last_word;

  // Only 1- and 2-word reads touch the bus; anything else is reported via res.
  assign cmd_legal = (word_num_q == 2'd1) || (word_num_q == 2'd2);
  assign last_word = (word_num_q != 2'd2) || word_idx_q;

  // Next-state and registered-output logic. Every pin is driven from a
  // register so p_rd cannot glitch; p_rd_d defaults high and is pulled low
  // only for cycles that will be spent in STROBE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    word_num_d = word_num_q;
    p_addr_d   = p_addr_q;
    p_rd_d     = 1'b1;
    reg_rvar_d = reg_rvar_q;
    res_d      = res_q;
    busy_d     = busy_q;
    finish_d   = finish_q;
`ifdef AD9914_RD_VERIFY_EN
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
`endif

    case (state_q)
      IDLE: begin
        if (port_if.load) begin
          word_num_d = port_if.reg_word_num;
          word_idx_d = 1'b0;
          cnt_d      = 16'd0;
          res_d      = 1'b0;
          busy_d     = 1'b1;
          finish_d   = 1'b0;
          state_d    = SETUP;
`ifdef AD9914_RD_VERIFY_EN
          exp_d      = port_if.exp_var;
          mismatch_d = 1'b0;
`endif
          // An illegal command must not touch the bus, so the address is
          // only updated for a read that will actually happen.
          if ((port_if.reg_word_num == 2'd1) || (port_if.reg_word_num == 2'd2)) begin
            p_addr_d = port_if.reg_base_addr;
          end
        end
      end

      SETUP: begin
        if (!cmd_legal) begin
          res_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == S_LAST) begin
          cnt_d   = 16'd0;
          p_rd_d  = 1'b0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STROBE: begin
        if (cnt_q == P_LAST) begin
          // Data is taken at the end of the last low cycle, when the DDS
          // output has had the full pulse width to settle.
          cnt_d   = 16'd0;
          state_d = RECOVER;
          if (word_idx_q) begin
            reg_rvar_d[31:16] = port_if.p_rdata;
          end else begin
            reg_rvar_d = {16'h0000, port_if.p_rdata};
          end
        end else begin
          cnt_d  = cnt_q + 16'd1;
          p_rd_d = 1'b0;
        end
      end

      RECOVER: begin
        if (cnt_q == R_LAST) begin
          cnt_d = 16'd0;
          if (last_word) begin
            state_d = DONE;
          end else begin
            // Registers are 16 bits wide and live at even addresses, so the
            // second word is two addresses up; the 8-bit add wraps 0xFF to 0x01.
            word_idx_d = 1'b1;
            p_addr_d   = p_addr_q + 8'd2;
            state_d    = SETUP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: begin
        busy_d   = 1'b0;
        finish_d = 1'b1;
        state_d  = IDLE;
`ifdef AD9914_RD_VERIFY_EN
        // A 1-word read only owns the low half, so only that half is compared.
        if (res_q) begin
          mismatch_d = 1'b0;
        end else if (word_num_q == 2'd2) begin
          mismatch_d = (reg_rvar_q != exp_q);
        end else begin
          mismatch_d = (reg_rvar_q[15:0] != exp_q[15:0]);
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset forces the strobe inactive at once and
  // throws away any partially assembled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      word_idx_q <= 1'b0;
      word_num_q <= 2'd0;
      p_addr_q   <= 8'd0;
      p_rd_q     <= 1'b1;
      reg_rvar_q <= 32'd0;
      res_q      <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b1;
`ifdef AD9914_RD_VERIFY_EN
      exp_q      <= 32'd0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      word_num_q <= word_num_d;
      p_addr_q   <= p_addr_d;
      p_rd_q     <= p_rd_d;
      reg_rvar_q <= reg_rvar_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
`ifdef AD9914_RD_VERIFY_EN
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign port_if.p_pwd           = 1'b1;
  assign port_if.p_wr            = 1'b1;
  assign port_if.data_tri_select = 1'b0;
  assign port_if.p_rd            = p_rd_q;
  assign port_if.p_addr          = p_addr_q;
  assign port_if.reg_rvar        = reg_rvar_q;
  assign port_if.res             = res_q;
  assign port_if.busy            = busy_q;
  assign port_if.finish          = finish_q;
`ifdef AD9914_RD_VERIFY_EN
  assign port_if.mismatch        = mismatch_q;
`else
  assign port_if.mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_ad9914_reg_rd.sv
// ---------------------------------------------------------------------------
// tb_ad9914_reg_rd
//
// Directed testbench for ad9914_reg_rd with default timing parameters
// (W = 8 cycles per word). A small DDS model answers p_rd with a table
// lookup on p_addr; monitors count p_rd pulses, low cycles and strobe
// addresses. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ad9914_reg_rd;

  logic clk;
  logic rst;

  ad9914_reg_rd_if ifc ();

  ad9914_reg_rd dut (
    .clk     (clk),
    .rst     (rst),
    .port_if (ifc)
  );

`ifdef AD9914_RD_VERIFY_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] dds [256];
  int          pulseCnt;
  int          lowCnt;
  logic [7:0]  addrQ [$];

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DDS model: drives the addressed register only while p_rd is low, so a
  // capture outside the strobe shows up as 16'hDEAD.
  assign ifc.p_rdata = ifc.p_rd ? 16'hDEAD : dds[ifc.p_addr];

  // Record each strobe and the address presented when it falls
  always @(negedge ifc.p_rd) begin
    pulseCnt++;
    addrQ.push_back(ifc.p_addr);
  end

  // Count clock cycles spent with p_rd low
  always @(negedge clk) begin
    if (ifc.p_rd === 1'b0) lowCnt++;
  end

  // Issue one command and count edges from the accept edge to finish.
  // holdExtra keeps load high that many edges after accept; midPulse raises
  // load again for edge 8 only. edges is -1 if finish never rises.
  task automatic applyStimulus(input logic [7:0] base, input logic [1:0] n,
                               input logic [31:0] expv, input int holdExtra,
                               input bit midPulse, output int edges,
                               output bit acceptOk);
    pulseCnt = 0;
    lowCnt   = 0;
    addrQ.delete();
    edges = -1;
    @(negedge clk);
    ifc.reg_base_addr = base;
    ifc.reg_word_num  = n;
    ifc.exp_var       = expv;
    ifc.load          = 1'b1;
    @(posedge clk);
    #1;
    acceptOk = (ifc.busy === 1'b1) && (ifc.finish === 1'b0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      ifc.load = (k <= holdExtra) || (midPulse && (k == 8));
      @(posedge clk);
      #1;
      if (ifc.finish === 1'b1) begin
        edges = k;
        break;
      end
    end
    ifc.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifc.p_rd !== 1'b1 || ifc.busy !== 1'b0 || ifc.finish !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: p_rd/busy/finish got %b%b%b, expected 101", ifc.p_rd, ifc.busy, ifc.finish);
    end
    checks++;
    if (ifc.reg_rvar !== 32'd0 || ifc.p_addr !== 8'd0 || ifc.res !== 1'b0 || ifc.mismatch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: reg_rvar=%h p_addr=%h res=%b mismatch=%b, expected all zero", ifc.reg_rvar, ifc.p_addr, ifc.res, ifc.mismatch);
    end
    checks++;
    if (ifc.p_wr !== 1'b1 || ifc.p_pwd !== 1'b1 || ifc.data_tri_select !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_const: p_wr/p_pwd/tri got %b%b%b, expected 110", ifc.p_wr, ifc.p_pwd, ifc.data_tri_select);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_two_word();
    int edges;
    bit acc;
    applyStimulus(8'h04, 2'd2, 32'd0, 0, 1'b0, edges, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL two_word_accept: busy=%b finish=%b after edge 0, expected busy=1 finish=0", ifc.busy, ifc.finish);
    end
    checks++;
    if (edges !== 17) begin
      errors++;
      $display("[TB] FAIL two_word_finish_edge: got %0d, expected 17", edges);
    end
    checks++;
    if (pulseCnt !== 2 || lowCnt !== 8) begin
      errors++;
      $display("[TB] FAIL two_word_strobes: pulses=%0d low=%0d, expected 2 and 8", pulseCnt, lowCnt);
    end
    checks++;
    if (addrQ.size() != 2 || addrQ[0] !== 8'h04 || addrQ[1] !== 8'h06) begin
      errors++;
      $display("[TB] FAIL two_word_addr: %0d strobes, first=%h, expected 04 then 06", addrQ.size(), (addrQ.size() > 0) ? addrQ[0] : 8'hxx);
    end
    checks++;
    if (ifc.reg_rvar !== 32'h41E12465 || ifc.res !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL two_word_data: reg_rvar=%h res=%b busy=%b, expected 41e12465 0 0", ifc.reg_rvar, ifc.res, ifc.busy);
    end
  endtask

  task automatic test_one_word();
    int edges;
    bit acc;
    applyStimulus(8'h0C, 2'd1, 32'd0, 0, 1'b0, edges, acc);
    checks++;
    if (edges !== 9) begin
      errors++;
      $display("[TB] FAIL one_word_finish_edge: got %0d, expected 9", edges);
    end
    checks++;
    if (pulseCnt !== 1 || lowCnt !== 4) begin
      errors++;
      $display("[TB] FAIL one_word_strobes: pulses=%0d low=%0d, expected 1 and 4", pulseCnt, lowCnt);
    end
    checks++;
    if (ifc.reg_rvar !== 32'h00000FFF) begin
      errors++;
      $display("[TB] FAIL one_word_data: got %h, expected 00000fff", ifc.reg_rvar);
    end
  endtask

  task automatic test_illegal();
    int edges;
    bit acc;
    logic [1:0] badN [2];
    badN[0] = 2'd0;
    badN[1] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'h30, badN[i], 32'd0, 0, 1'b0, edges, acc);
      checks++;
      if (edges !== 2) begin
        errors++;
        $display("[TB] FAIL illegal_finish_edge n=%0d: got %0d, expected 2", badN[i], edges);
      end
      checks++;
      if (pulseCnt !== 0 || ifc.res !== 1'b1 || ifc.mismatch !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_status n=%0d: pulses=%0d res=%b mismatch=%b, expected 0 1 0", badN[i], pulseCnt, ifc.res, ifc.mismatch);
      end
      checks++;
      if (ifc.reg_rvar !== 32'h00000FFF) begin
        errors++;
        $display("[TB] FAIL illegal_data n=%0d: got %h, expected 00000fff", badN[i], ifc.reg_rvar);
      end
    end
  endtask

  task automatic test_reset_midstrobe();
    int edges;
    bit acc;
    @(negedge clk);
    ifc.reg_base_addr = 8'h04;
    ifc.reg_word_num  = 2'd2;
    ifc.load          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.load = 1'b0;
    // Word 1 strobe starts at edge 10; edge 11 begins its second low cycle
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (ifc.p_rd !== 1'b0 || ifc.reg_rvar !== 32'h00002465) begin
      errors++;
      $display("[TB] FAIL midstrobe_pre: p_rd=%b reg_rvar=%h, expected 0 00002465", ifc.p_rd, ifc.reg_rvar);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.p_rd !== 1'b1 || ifc.busy !== 1'b0 || ifc.finish !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midstrobe_reset_ctrl: p_rd/busy/finish got %b%b%b, expected 101", ifc.p_rd, ifc.busy, ifc.finish);
    end
    checks++;
    if (ifc.reg_rvar !== 32'd0 || ifc.p_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midstrobe_reset_data: reg_rvar=%h p_addr=%h, expected 0 0", ifc.reg_rvar, ifc.p_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h0C, 2'd1, 32'd0, 0, 1'b0, edges, acc);
    checks++;
    if (edges !== 9 || ifc.reg_rvar !== 32'h00000FFF) begin
      errors++;
      $display("[TB] FAIL midstrobe_recover: edge=%0d reg_rvar=%h, expected 9 00000fff", edges, ifc.reg_rvar);
    end
  endtask

  task automatic test_verify();
    int edges;
    bit acc;
    applyStimulus(8'h20, 2'd2, 32'h00012345, 0, 1'b0, edges, acc);
    checks++;
    if (ifc.reg_rvar !== 32'h00012345 || ifc.mismatch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL verify_equal: reg_rvar=%h mismatch=%b, expected 00012345 0", ifc.reg_rvar, ifc.mismatch);
    end
    applyStimulus(8'h20, 2'd2, 32'h00012344, 0, 1'b0, edges, acc);
    checks++;
    if (ifc.mismatch !== EXP_MIS) begin
      errors++;
      $display("[TB] FAIL verify_differ: mismatch=%b, expected %b", ifc.mismatch, EXP_MIS);
    end
    applyStimulus(8'h0C, 2'd1, 32'hFFFF0FFF, 0, 1'b0, edges, acc);
    checks++;
    if (ifc.mismatch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL verify_mask_upper: mismatch=%b, expected 0", ifc.mismatch);
    end
    applyStimulus(8'h0C, 2'd1, 32'h00000FFE, 0, 1'b0, edges, acc);
    checks++;
    if (ifc.mismatch !== EXP_MIS) begin
      errors++;
      $display("[TB] FAIL verify_one_word_differ: mismatch=%b, expected %b", ifc.mismatch, EXP_MIS);
    end
  endtask

  task automatic test_wrap_load_hold();
    int edges;
    bit acc;
    applyStimulus(8'hFF, 2'd2, 32'd0, 3, 1'b1, edges, acc);
    checks++;
    if (edges !== 17 || pulseCnt !== 2) begin
      errors++;
      $display("[TB] FAIL wrap_timing: edge=%0d pulses=%0d, expected 17 2", edges, pulseCnt);
    end
    checks++;
    if (addrQ.size() != 2 || addrQ[0] !== 8'hFF || addrQ[1] !== 8'h01) begin
      errors++;
      $display("[TB] FAIL wrap_addr: %0d strobes, last=%h, expected ff then 01", addrQ.size(), (addrQ.size() > 0) ? addrQ[addrQ.size()-1] : 8'hxx);
    end
    checks++;
    if (ifc.reg_rvar !== 32'hCAFEBEEF) begin
      errors++;
      $display("[TB] FAIL wrap_data: got %h, expected cafebeef", ifc.reg_rvar);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.finish !== 1'b1 || pulseCnt !== 2) begin
      errors++;
      $display("[TB] FAIL wrap_no_restart: busy=%b finish=%b pulses=%0d, expected 0 1 2", ifc.busy, ifc.finish, pulseCnt);
    end
  endtask

  // Test sequence
  initial begin
    for (int a = 0; a < 256; a++) dds[a] = {8'hA5, 8'(a)};
    dds[8'h04] = 16'h2465;
    dds[8'h06] = 16'h41E1;
    dds[8'h0C] = 16'h0FFF;
    dds[8'h20] = 16'h2345;
    dds[8'h22] = 16'h0001;
    dds[8'hFF] = 16'hBEEF;
    dds[8'h01] = 16'hCAFE;
    ifc.load          = 1'b0;
    ifc.reg_base_addr = 8'h00;
    ifc.reg_word_num  = 2'd0;
    ifc.exp_var       = 32'd0;
    pulseCnt = 0;
    lowCnt   = 0;

    test_reset();
    test_two_word();
    test_one_word();
    test_illegal();
    test_reset_midstrobe();
    test_verify();
    test_wrap_load_hold();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
